// File: rtl/cv32e40x_obi_txn_tracker.sv
// cv32e40x_obi_txn_tracker
//   Bridges the MPU bus-side valid/ready transfer interface onto the OBI data bus.
//   A request that is not granted in its first cycle is parked in a hold register so
//   that obi_req_o and the address/attributes stay stable until grant. Granted-but-
//   unanswered transactions are counted (limited to DEPTH), and the write flag of each
//   is queued so that every response can be tagged read/write.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   trans_*               transfer request from the MPU (valid/ready)
//   obi_*                 OBI request (req/gnt) and response (rvalid) channels
//   resp_*                response to MPU/core, combinational from the OBI response
//   outstanding_o         registered count of outstanding transactions
//   one_txn_pend_n_o      next cycle has exactly one pending transaction
module cv32e40x_obi_txn_tracker #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trans_valid_i,
   output logic             trans_ready_o,
   input  logic [31:0]      trans_addr_i,
   input  logic             trans_we_i,
   input  logic [3:0]       trans_be_i,
   input  logic [31:0]      trans_wdata_i,
   output logic             obi_req_o,
   input  logic             obi_gnt_i,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [3:0]       obi_be_o,
   output logic [31:0]      obi_wdata_o,
   input  logic             obi_rvalid_i,
   input  logic [31:0]      obi_rdata_i,
   input  logic             obi_err_i,
   output logic             resp_valid_o,
   output logic [31:0]      resp_rdata_o,
   output logic             resp_err_o,
   output logic             resp_we_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             one_txn_pend_n_o
);

   localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W:0] DEPTH_P = (CNT_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e             state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic               we_q, we_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH-1:0]   fifo_q, fifo_d;
   logic [CNT_W:0]     pend, pend_n;
   logic               grant, pop;

   // Request FSM
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      we_d          = we_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      trans_ready_o = 1'b0;
      obi_req_o     = 1'b0;
      obi_addr_o    = trans_addr_i;
      obi_we_o      = trans_we_i;
      obi_be_o      = trans_be_i;
      obi_wdata_o   = trans_wdata_i;
      // A parked request already occupies one slot of capacity.
      pend = {1'b0, count_q} + {{CNT_W{1'b0}}, state_q == StHold};
      unique case (state_q)
         StIdle: begin
            // Gated by rst_n so nothing is accepted while reset is held.
            trans_ready_o = rst_n && (pend < DEPTH_P);
            obi_req_o     = trans_valid_i && trans_ready_o;
            if (obi_req_o && !obi_gnt_i) begin
               addr_d  = trans_addr_i;
               we_d    = trans_we_i;
               be_d    = trans_be_i;
               wdata_d = trans_wdata_i;
               state_d = StHold;
            end
         end
         StHold: begin
            obi_req_o   = 1'b1;
            obi_addr_o  = addr_q;
            obi_we_o    = we_q;
            obi_be_o    = be_q;
            obi_wdata_o = wdata_q;
            if (obi_gnt_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outstanding counter and write-flag FIFO
   always_comb begin
      grant  = obi_req_o && obi_gnt_i;
      // A response with nothing outstanding is ignored: no underflow, no pointer move.
      pop    = obi_rvalid_i && (count_q != '0);
      fifo_d = fifo_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (grant) begin
         fifo_d[wptr_q] = obi_we_o;
         wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(grant) - CNT_W'(pop);
      pend_n  = {1'b0, count_d} + {{CNT_W{1'b0}}, state_d == StHold};
      one_txn_pend_n_o = (pend_n == (CNT_W + 1)'(1));
   end

   assign resp_valid_o  = obi_rvalid_i;
   assign resp_rdata_o  = obi_rdata_i;
   assign resp_err_o    = obi_err_i;
   assign resp_we_o     = (count_q != '0) && fifo_q[rptr_q];
   assign outstanding_o = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         fifo_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         fifo_q  <= fifo_d;
      end
   end

`ifndef SYNTHESIS
   // Protocol monitors: a stalled OBI request must persist unchanged, and a response
   // must not arrive with nothing outstanding.
   logic        chk_stall_q;
   logic [68:0] chk_attr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_stall_q <= 1'b0;
         chk_attr_q  <= '0;
      end else begin
         if (chk_stall_q) begin
            assert (obi_req_o && ({obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o} == chk_attr_q))
               else $error("OBI request dropped or changed before grant");
         end
         assert (!(obi_rvalid_i && (count_q == '0)))
            else $warning("obi_rvalid_i with no outstanding transaction");
         chk_stall_q <= obi_req_o && !obi_gnt_i;
         chk_attr_q  <= {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o};
      end
   end
`endif

endmodule

// File: doc/cv32e40x_obi_txn_tracker.md
Name: cv32e40x_obi_txn_tracker

Overview:
- Sits directly downstream of the MPU on the data side, between the MPU bus-side transfer interface and the OBI data bus.
- Converts the MPU valid/ready transfer handshake into an OBI-compliant req/gnt request, holding address and attributes stable until the request is granted.
- Counts outstanding (granted but not yet responded) transactions and limits them to DEPTH.
- Stores the write flag of each granted transaction in a FIFO so every response is tagged read/write, and produces a next-cycle "exactly one pending" indication for the MPU error-wait FSM.

Parameters:
DEPTH, 2, maximum number of outstanding OBI transactions (1..8)
CNT_W, $clog2(DEPTH+1), width of the outstanding counter (derived; not to be overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
trans_valid_i  input  1  transfer request from MPU
trans_ready_o  output  1  transfer accepted
trans_addr_i  input  32  address
trans_we_i  input  1  write enable
trans_be_i  input  4  byte enables
trans_wdata_i  input  32  write data
obi_req_o  output  1  OBI request
obi_gnt_i  input  1  OBI grant
obi_addr_o  output  32  OBI address
obi_we_o  output  1  OBI write enable
obi_be_o  output  4  OBI byte enables
obi_wdata_o  output  32  OBI write data
obi_rvalid_i  input  1  OBI response valid
obi_rdata_i  input  32  OBI read data
obi_err_i  input  1  OBI bus error
resp_valid_o  output  1  response to MPU/core
resp_rdata_o  output  32  response read data
resp_err_o  output  1  response bus error
resp_we_o  output  1  response belongs to a write
outstanding_o  output  CNT_W  current outstanding count
one_txn_pend_n_o  output  1  next cycle will have exactly one pending transaction

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE; hold register cleared; count = 0; FIFO read and write pointers = 0.
  - obi_req_o = 0; trans_ready_o = 0 while in reset.
  - resp_valid_o follows obi_rvalid_i and is 0 with a quiet bus.
  - one_txn_pend_n_o = 0.
- Capacity: pend = count + (state==HOLD). A new transfer may be accepted only when pend < DEPTH.
- FSM IDLE:
  - trans_ready_o = (pend < DEPTH).
  - obi_req_o = trans_valid_i && trans_ready_o; OBI address and attributes are driven straight from the trans_* inputs.
  - On acceptance with obi_gnt_i = 1: transaction is granted in the same cycle; stay in IDLE.
  - On acceptance with obi_gnt_i = 0: latch addr/we/be/wdata into the hold register; go to HOLD.
- FSM HOLD:
  - trans_ready_o = 0; obi_req_o = 1; OBI outputs are driven from the hold register and stay stable until grant.
  - On obi_gnt_i = 1: go to IDLE. A new transfer can be accepted no earlier than the next cycle.
- Grant event: grant = obi_req_o && obi_gnt_i.
  - count increments.
  - The write-enable bit of the granted transaction is pushed into the DEPTH-entry FIFO; the write pointer wraps modulo DEPTH.
- Response path:
  - resp_valid_o = obi_rvalid_i; resp_rdata_o = obi_rdata_i; resp_err_o = obi_err_i. Combinational, zero latency, no backpressure.
  - resp_we_o = FIFO head.
  - When obi_rvalid_i is high, count decrements and the read pointer advances (wraps modulo DEPTH).
- Grant and rvalid in the same cycle: count is unchanged; FIFO pushes and pops together. With FIFO full (count == DEPTH) this is legal only if the pop frees the entry; the push writes the freed slot.
- A response never frees capacity in the same cycle: acceptance uses the registered count.
- obi_rvalid_i with count == 0 is a protocol violation:
  - count must not underflow, the pointers must not move, and resp_we_o = 0.
  - Flagged by an assertion.
- one_txn_pend_n_o = (count_n + (state_n==HOLD)) == 1, where count_n and state_n are the next-state values.
- outstanding_o = count (registered).
- OBI rule: once obi_req_o rises it must not fall, and addr/we/be/wdata must not change until grant. Guaranteed by the HOLD state; covered by an assertion.
- Reset asserted mid-transaction: all state clears immediately. Responses still in flight afterwards fall under the count == 0 rule.

Test Plan:
- Single read, gnt in the same cycle, rvalid 2 cycles later with rdata = 0xDEADBEEF -> count 0→1→0; resp_valid_o pulses once with rdata 0xDEADBEEF, resp_we_o = 0; one_txn_pend_n_o high in the cycle of the grant.
- Write to 0x1000_0004, be = 0xC, gnt withheld 3 cycles -> HOLD entered; obi_addr_o/be/wdata stable for all 4 req cycles; trans_ready_o = 0 until the grant; resp_we_o = 1 on the response.
- DEPTH = 2, back-to-back reads, gnt always 1, no rvalid -> third transfer stalled with trans_ready_o = 0 and outstanding_o = 2; first rvalid -> trans_ready_o = 1 in the following cycle.
- Alternating W, R, W, R granted with responses interleaved so grant and rvalid coincide -> count stays constant; resp_we_o sequence is 1, 0, 1, 0 across FIFO pointer wrap.
- Spurious obi_rvalid_i with count = 0 -> outstanding_o stays 0; assertion fires; resp_we_o = 0.
- rst_n asserted while in HOLD with count = 1 -> obi_req_o drops asynchronously; outstanding_o = 0; state IDLE after release.
